fp_multiplier_param: RTL and testbench
======================================

Name: fp_multiplier_param

Overview:
Parametrised IEEE-754-style floating-point multiplier, successor to the fixed float32 multiplier. It keeps the same three stb/ack channels (A, B, Z) and generalises the format through EXP_W/MAN_W. Adds full special-case handling, round-to-nearest-even, overflow saturation to infinity and underflow flush. Sits on the FPU operand bus as a multi-cycle, one-operation-at-a-time unit.

Parameters:
EXP_W, 8, exponent field width (>=3); BIAS = 2^(EXP_W-1)-1
MAN_W, 23, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
input_a  in  W  operand A
input_a_stb  in  1  operand A valid
input_a_ack  out  1  operand A ready; transfer when stb&&ack at a rising edge
input_b  in  W  operand B
input_b_stb  in  1  operand B valid
input_b_ack  out  1  operand B ready
output_z  out  W  result, registered
output_z_stb  out  1  result valid
output_z_ack  in  1  result accepted

Behaviour:
- Reset (async, any state): state=GET_A; input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0. An in-flight operation is discarded.
- FSM: GET_A -> GET_B -> UNPACK -> MULTIPLY -> NORMALIZE -> ROUND -> PACK -> PUT_Z -> GET_A.
- input_a_ack is registered and is 1 exactly while in GET_A. The first cycle after reset has ack=0. A is captured on the edge where stb&&ack; that edge enters GET_B and ack drops in the same edge. B behaves identically in GET_B.
- Latency is fixed: B captured at edge N -> output_z_stb rises at edge N+5. It is independent of operand class; special cases still traverse every state.
- PUT_Z: output_z and output_z_stb are held stable until an edge with output_z_ack=1. At that edge stb clears and the state returns to GET_A.
- output_z_ack while stb=0 is ignored. Ack already high when stb rises completes the transfer at the next edge. Back-to-back throughput is 1 result per 8 cycles minimum.
- UNPACK classifies each operand as zero, subnormal, normal, inf or NaN. Subnormal inputs are flushed to signed zero. Hidden bit 1 is prepended to normals.
- Sign: z_s = a_s ^ b_s. This applies to all results except NaN.
- Special-case priority:
  - any NaN in, or inf*zero -> canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
  - else inf*x -> signed inf.
  - else zero*x -> signed zero.
- Exponent datapath: signed, EXP_W+2 bits, z_e = a_e + b_e - BIAS. No wrap is permitted.
- Product: (MAN_W+1)x(MAN_W+1) -> 2*MAN_W+2 bits.
- NORMALIZE: if product MSB=1, take the fraction from the bits below the MSB and do z_e+1. Otherwise take one bit lower. Guard = next bit, round = next, sticky = OR of all remaining bits.
- ROUND is round-to-nearest, ties-to-even: increment when guard && (round || sticky || fraction LSB). A carry out of the fraction sets fraction=0 and z_e+1.
- PACK range checks (after rounding):
  - z_e >= 2^EXP_W-1 -> signed inf.
  - z_e <= 0 -> signed zero; no subnormal outputs are produced.
  - Otherwise z = {z_s, z_e[EXP_W-1:0], fraction}.

Optional Feature:
Macro FPMUL_EXC_FLAGS_EN.
- Defined: adds output port output_flags[3:0] = {invalid, overflow, underflow, inexact}. It is registered and updated with output_z in PACK, held through PUT_Z, and reset to 0.
- Flag definitions:
  - invalid: NaN result from inf*zero, or any NaN input.
  - overflow: result saturated to inf from finite inputs.
  - underflow: result flushed to zero from a nonzero finite product.
  - inexact: guard|round|sticky nonzero, or overflow/underflow set.
- Not defined: the port is absent, flag logic is not synthesised, and all other behaviour is identical.

Test Plan:
- Latency and basic multiply: 0x40000000 (2.0) * 0x40400000 (3.0) -> 0x40C00000. output_z_stb rises exactly 5 edges after the B transfer; flags 0.
- Sign handling: 0xBFC00000 * 0x3FC00000 -> 0xC0100000 (-2.25).
- Tie-to-even: 0x3F800001 * 0x3FC00000 -> 0x3FC00002 with inexact=1. Also 0x3F800001 * 0x3F800001 -> 0x3F800002.
- Special cases:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000 with invalid=1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000.
  - 0x00400000 (subnormal) * 0x40000000 -> 0x00000000.
- Overflow and underflow:
  - 0x7F000000 * 0x40000000 -> 0x7F800000 with overflow=1.
  - 0x00800000 * 0x3F000000 -> 0x00000000 with underflow=1.
- Handshake and reset:
  - Hold output_z_ack=0 for 10 cycles -> output_z and stb remain stable.
  - Ack pulse -> stb low next edge and input_a_ack high.
  - Assert rst asynchronously during MULTIPLY -> all acks and stb go 0 immediately without a clock edge. The next operation computes correctly.

Source files
------------

// File: rtl/fp_multiplier_param.sv
// Parametrised floating-point multiplier (EXP_W/MAN_W) with RNE rounding, IEEE special cases, overflow to inf and underflow flush.
// Latency: B accepted at edge N -> output_z_stb at edge N+5, fixed for every operand class; one operation in flight at a time.
// Backpressure: result held in PUT_Z until output_z_ack; A/B acks only open in GET_A/GET_B. Optional macro FPMUL_EXC_FLAGS_EN adds output_flags.
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic         input_a_stb,
  output logic         input_a_ack,
  input  logic [W-1:0] input_b,
  input  logic         input_b_stb,
  output logic         input_b_ack,
  output logic [W-1:0] output_z,
  output logic         output_z_stb,
  input  logic         output_z_ack
`ifdef FPMUL_EXC_FLAGS_EN
  ,
  output logic [3:0]   output_flags
`endif
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [EW2-1:0] BIAS_E = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EMAX_E = EW2'(EMAX);
  localparam logic signed [EW2-1:0] ONE_E  = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO_E = EW2'(0);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_GET_A, S_GET_B, S_UNPACK, S_MULTIPLY, S_NORMALIZE, S_ROUND, S_PACK, S_PUT_Z
  } state_t;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  state_t r_state, w_next_state;

  logic [W-1:0]            r_a, r_b;
  logic [MAN_W:0]          r_a_m, r_b_m;
  logic signed [EW2-1:0]   r_a_e, r_b_e, r_z_e;
  logic                    r_z_s;
  spec_t                   r_spec;
  logic [PW-1:0]           r_prod;
  logic [MAN_W-1:0]        r_frac;
  logic                    r_guard, r_round, r_sticky;
  logic                    r_a_ack, r_b_ack, r_z_stb;
  logic [W-1:0]            r_z;
  logic                    w_a_ack_nxt, w_b_ack_nxt, w_z_stb_nxt;

  // Operand field decode and classification
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  spec_t w_spec;

  assign w_a_exp  = r_a[W-2:MAN_W];
  assign w_b_exp  = r_b[W-2:MAN_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
  assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
  assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
  assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
  // Zero exponent covers both true zero and subnormals, which are flushed
  assign w_a_zero = ~(|w_a_exp);
  assign w_b_zero = ~(|w_b_exp);

  // Special-case priority: NaN (incl. inf*0) over inf over zero
  always_comb begin
    w_spec = SP_NONE;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_spec = SP_NAN;
    else if (w_a_inf || w_b_inf)
      w_spec = SP_INF;
    else if (w_a_zero || w_b_zero)
      w_spec = SP_ZERO;
  end

  // Normalisation: shift so the product MSB is set; the shifted-in zero never affects sticky
  logic [PW-1:0] w_norm;
  assign w_norm = r_prod[PW-1] ? r_prod : (r_prod << 1);

  // Round-to-nearest-even increment with carry detection
  logic           w_rnd_up;
  logic [MAN_W:0] w_frac_inc;
  assign w_rnd_up   = r_guard & (r_round | r_sticky | r_frac[0]);
  assign w_frac_inc = {1'b0, r_frac} + (MAN_W+1)'(1);

  // Final packing with range checks on the rounded exponent
  logic [W-1:0] w_pack_z;
  logic         w_range_inf, w_range_zero;
  assign w_range_inf  = (r_z_e >= EMAX_E);
  assign w_range_zero = (r_z_e <= ZERO_E);

  // Select the packed result from special class or range check
  always_comb begin
    w_pack_z = '0;
    unique case (r_spec)
      SP_NAN:  w_pack_z = QNAN;
      SP_INF:  w_pack_z = {r_z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: w_pack_z = {r_z_s, {(W-1){1'b0}}};
      default: begin
        if (w_range_inf)
          w_pack_z = {r_z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_range_zero)
          w_pack_z = {r_z_s, {(W-1){1'b0}}};
        else
          w_pack_z = {r_z_s, r_z_e[EXP_W-1:0], r_frac};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_GET_A;
    else     r_state <= w_next_state;
  end

  // Next-state logic: fixed walk through the pipeline states, handshakes gate GET_A/GET_B/PUT_Z
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_GET_A:     if (input_a_stb && r_a_ack) w_next_state = S_GET_B;
      S_GET_B:     if (input_b_stb && r_b_ack) w_next_state = S_UNPACK;
      S_UNPACK:    w_next_state = S_MULTIPLY;
      S_MULTIPLY:  w_next_state = S_NORMALIZE;
      S_NORMALIZE: w_next_state = S_ROUND;
      S_ROUND:     w_next_state = S_PACK;
      S_PACK:      w_next_state = S_PUT_Z;
      S_PUT_Z:     if (r_z_stb && output_z_ack) w_next_state = S_GET_A;
      default:     w_next_state = S_GET_A;
    endcase
  end

  // Output decode: handshake signals follow the state being entered, so they are registered
  always_comb begin
    w_a_ack_nxt = (w_next_state == S_GET_A);
    w_b_ack_nxt = (w_next_state == S_GET_B);
    w_z_stb_nxt = (w_next_state == S_PUT_Z);
  end

  // Handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_z_stb <= 1'b0;
    end else begin
      r_a_ack <= w_a_ack_nxt;
      r_b_ack <= w_b_ack_nxt;
      r_z_stb <= w_z_stb_nxt;
    end
  end

  // Datapath: each state performs one step of the multiply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_a_m    <= '0;
      r_b_m    <= '0;
      r_a_e    <= '0;
      r_b_e    <= '0;
      r_z_e    <= '0;
      r_z_s    <= 1'b0;
      r_spec   <= SP_NONE;
      r_prod   <= '0;
      r_frac   <= '0;
      r_guard  <= 1'b0;
      r_round  <= 1'b0;
      r_sticky <= 1'b0;
      r_z      <= '0;
    end else begin
      unique case (r_state)
        S_GET_A: if (input_a_stb && r_a_ack) r_a <= input_a;
        S_GET_B: if (input_b_stb && r_b_ack) r_b <= input_b;
        S_UNPACK: begin
          r_a_m  <= w_a_zero ? '0 : {1'b1, w_a_frac};
          r_b_m  <= w_b_zero ? '0 : {1'b1, w_b_frac};
          r_a_e  <= {2'b00, w_a_exp};
          r_b_e  <= {2'b00, w_b_exp};
          r_z_s  <= r_a[W-1] ^ r_b[W-1];
          r_spec <= w_spec;
        end
        S_MULTIPLY: begin
          r_prod <= PW'(r_a_m) * PW'(r_b_m);
          r_z_e  <= r_a_e + r_b_e - BIAS_E;
        end
        S_NORMALIZE: begin
          r_frac   <= w_norm[PW-2 -: MAN_W];
          r_guard  <= w_norm[MAN_W];
          r_round  <= w_norm[MAN_W-1];
          r_sticky <= |w_norm[MAN_W-2:0];
          if (r_prod[PW-1]) r_z_e <= r_z_e + ONE_E;
        end
        S_ROUND: begin
          if (w_rnd_up) begin
            r_frac <= w_frac_inc[MAN_W-1:0];
            if (w_frac_inc[MAN_W]) r_z_e <= r_z_e + ONE_E;
          end
        end
        S_PACK:  r_z <= w_pack_z;
        default: ;
      endcase
    end
  end

`ifdef FPMUL_EXC_FLAGS_EN
  logic [3:0] r_flags;
  logic       w_ovf, w_udf, w_inv, w_inx;
  assign w_ovf = (r_spec == SP_NONE) & w_range_inf;
  assign w_udf = (r_spec == SP_NONE) & ~w_range_inf & w_range_zero;
  assign w_inv = (r_spec == SP_NAN);
  assign w_inx = ((r_spec == SP_NONE) & (r_guard | r_round | r_sticky)) | w_ovf | w_udf;

  // Exception flags load alongside the result and hold through PUT_Z
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_flags <= 4'b0000;
    else if (r_state == S_PACK) r_flags <= {w_inv, w_ovf, w_udf, w_inx};
  end

  assign output_flags = r_flags;
`endif

  assign input_a_ack  = r_a_ack;
  assign input_b_ack  = r_b_ack;
  assign output_z     = r_z;
  assign output_z_stb = r_z_stb;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Directed bench for fp_multiplier_param (float32 configuration).
// Checks latency, rounding, special cases, range saturation, handshake hold and async reset.
// Flag checks only apply when FPMUL_EXC_FLAGS_EN is defined.
module tb_fp_multiplier_param;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] input_a, input_b;
  logic         input_a_stb, input_b_stb, output_z_ack;
  logic         input_a_ack, input_b_ack, output_z_stb;
  logic [W-1:0] output_z;
`ifdef FPMUL_EXC_FLAGS_EN
  logic [3:0]   output_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fp_multiplier_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
`ifdef FPMUL_EXC_FLAGS_EN
    ,
    .output_flags (output_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [W-1:0] a);
    input_a     = a;
    input_a_stb = 1'b1;
    for (int n = 0; n < 40 && !input_a_ack; n++) begin
      @(posedge clk); #1;
    end
    check("a_ack_wait", 64'(input_a_ack), 64'd1);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    check("a_ack_drop", 64'(input_a_ack), 64'd0);
  endtask

  task automatic send_b(input logic [W-1:0] b);
    input_b     = b;
    input_b_stb = 1'b1;
    for (int n = 0; n < 40 && !input_b_ack; n++) begin
      @(posedge clk); #1;
    end
    check("b_ack_wait", 64'(input_b_ack), 64'd1);
    @(posedge clk); #1;
    input_b_stb = 1'b0;
    check("b_ack_drop", 64'(input_b_ack), 64'd0);
  endtask

  // mode 0: plain ack, mode 1: hold ack low 10 cycles first, mode 2: ack high before stb rises
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] z_exp, input logic [3:0] flags_exp, input int mode);
    send_a(a);
    send_b(b);
    if (mode == 2) output_z_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_stb_early"}, 64'(output_z_stb), 64'd0);
    @(posedge clk); #1;
    check({tag, "_stb_lat"}, 64'(output_z_stb), 64'd1);
    check({tag, "_z"}, 64'(output_z), 64'(z_exp));
`ifdef FPMUL_EXC_FLAGS_EN
    check({tag, "_flags"}, 64'(output_flags), 64'(flags_exp));
`else
    if (flags_exp === 4'bxxxx) $display("flags_exp unknown for %s", tag);
`endif
    if (mode == 1) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_stb"}, 64'(output_z_stb), 64'd1);
        check({tag, "_hold_z"}, 64'(output_z), 64'(z_exp));
      end
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check({tag, "_stb_clr"}, 64'(output_z_stb), 64'd0);
    check({tag, "_a_ack_back"}, 64'(input_a_ack), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    input_a      = '0;
    input_b      = '0;
    input_a_stb  = 1'b0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;
    #12;
    check("rst_a_ack", 64'(input_a_ack), 64'd0);
    check("rst_b_ack", 64'(input_b_ack), 64'd0);
    check("rst_stb",   64'(output_z_stb), 64'd0);
    check("rst_z",     64'(output_z), 64'd0);
    rst = 1'b0;
    #1;
    check("first_cycle_a_ack", 64'(input_a_ack), 64'd0);

    run_op("mul_2x3",   32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 0);
    run_op("sign",      32'hBFC00000, 32'h3FC00000, 32'hC0100000, 4'b0000, 0);
    run_op("tie_even",  32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 0);
    run_op("sticky",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 0);
    run_op("inf_x0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    run_op("ninf_x2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0);
    run_op("subn_x2",   32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, 0);
    run_op("nan_in",    32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
    run_op("overflow",  32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 0);
    run_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 1);

    // Async reset in MULTIPLY: B transfer edge, then one more edge, then reset between edges
    send_a(32'h40000000);
    send_b(32'h40400000);
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a_ack", 64'(input_a_ack), 64'd0);
    check("async_rst_b_ack", 64'(input_b_ack), 64'd0);
    check("async_rst_stb",   64'(output_z_stb), 64'd0);
    check("async_rst_z",     64'(output_z), 64'd0);
    #2;
    rst = 1'b0;
    run_op("after_rst", 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
